pc_sequencer: RTL and testbench

// Parametrised program-counter sequencer for the HardCore datapath. It replaces the plain PC register with a
// RUN/WAIT_IN/HALT/TRAP state machine, an input-wait handshake and a hardware return-address stack for call/ret.
// It feeds the instruction memory address and takes its branch, jump and stop controls from UC, BranchControl and ULA.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/WAIT_IN/HALT/TRAP control with input-wait handshake
// and a hardware return-address stack for call/ret.
module pc_sequencer #(
    parameter int                  ADDR_W      = 32,
    parameter int                  STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    localparam int                 CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic              overflow,
    input  logic              wait_in,
    input  logic              inread,
    input  logic              resume,
    input  logic              branch_taken,
    input  logic              jump_en,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  stack_count,
    output logic              stack_full,
    output logic              stack_empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_HALT    = 2'd2,
        ST_TRAP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_OVERFLOW  = 2'd1,
        CAUSE_STACK_OVF = 2'd2,
        CAUSE_STACK_UNF = 2'd3
    } cause_e;

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              push_en;
    logic              full;
    logic              empty;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign push_idx = IDX_W'(count_q);
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign full     = (count_q == CNT_W'(STACK_DEPTH));
    assign empty    = (count_q == '0);

    always_comb begin
        // NOTE: every signal gets a hold default up front so no path leaves it unassigned (no latch).
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        count_d = count_q;
        push_en = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Priority order matters: stop conditions first, then stack ops, then flow changes.
                if (overflow) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_OVERFLOW;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (wait_in && !inread) begin
                    state_d = ST_WAIT_IN;
                end else if (ret && empty) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_STACK_UNF;
                end else if (ret) begin
                    pc_d    = stack_q[top_idx];
                    count_d = count_q - CNT_W'(1);
                end else if (call && full) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_STACK_OVF;
                end else if (call) begin
                    push_en = 1'b1;
                    pc_d    = jump_target;
                    count_d = count_q + CNT_W'(1);
                end else if (jump_en || branch_taken) begin
                    pc_d = jump_target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_WAIT_IN: begin
                if (inread) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // NOTE: stack storage is not reset; entries above stack_count are never read.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign trap_cause  = cause_q;
    assign stack_count = count_q;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three configurations share one stimulus stream and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        halt, overflow, wait_in, inread, resume;
    logic        branch_taken, jump_en, call, ret;
    logic [31:0] jump_target;

    logic [31:0] pc_d8, pc_d2;
    logic [3:0]  pc_a4;
    logic [1:0]  st_d8, st_d2, st_a4;
    logic [1:0]  tc_d8, tc_d2, tc_a4;
    logic [3:0]  cnt_d8, cnt_a4;
    logic [1:0]  cnt_d2;
    logic        full_d8, full_d2, full_a4;
    logic        empty_d8, empty_d2, empty_a4;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    pc_sequencer #(.ADDR_W(32), .STACK_DEPTH(8)) u_d8 (
        .clock(clock), .reset(reset), .halt(halt), .overflow(overflow), .wait_in(wait_in),
        .inread(inread), .resume(resume), .branch_taken(branch_taken), .jump_en(jump_en),
        .call(call), .ret(ret), .jump_target(jump_target), .pc(pc_d8), .state(st_d8),
        .trap_cause(tc_d8), .stack_count(cnt_d8), .stack_full(full_d8), .stack_empty(empty_d8)
    );

    pc_sequencer #(.ADDR_W(32), .STACK_DEPTH(2)) u_d2 (
        .clock(clock), .reset(reset), .halt(halt), .overflow(overflow), .wait_in(wait_in),
        .inread(inread), .resume(resume), .branch_taken(branch_taken), .jump_en(jump_en),
        .call(call), .ret(ret), .jump_target(jump_target), .pc(pc_d2), .state(st_d2),
        .trap_cause(tc_d2), .stack_count(cnt_d2), .stack_full(full_d2), .stack_empty(empty_d2)
    );

    pc_sequencer #(.ADDR_W(4), .STACK_DEPTH(8)) u_a4 (
        .clock(clock), .reset(reset), .halt(halt), .overflow(overflow), .wait_in(wait_in),
        .inread(inread), .resume(resume), .branch_taken(branch_taken), .jump_en(jump_en),
        .call(call), .ret(ret), .jump_target(jump_target[3:0]), .pc(pc_a4), .state(st_a4),
        .trap_cause(tc_a4), .stack_count(cnt_a4), .stack_full(full_a4), .stack_empty(empty_a4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rule-level model: index 0 = (32b, depth 8), 1 = (32b, depth 2), 2 = (4b, depth 8).
    int          cfg_aw    [3] = '{32, 32, 4};
    int          cfg_depth [3] = '{8, 2, 8};
    logic [31:0] m_pc      [3];
    int          m_st      [3];
    int          m_cause   [3];
    int          m_cnt     [3];
    logic [31:0] m_stk     [3][8];

    function automatic logic [31:0] wrap(int k, logic [31:0] v);
        logic [31:0] mask;
        mask = (cfg_aw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_aw[k]) - 32'd1);
        return v & mask;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_pc[k] = 32'd0; m_st[k] = 0; m_cause[k] = 0; m_cnt[k] = 0;
            end else if (m_st[k] == 0) begin
                if (overflow) begin
                    m_st[k] = 3; m_cause[k] = 1;
                end else if (halt) begin
                    m_st[k] = 2;
                end else if (wait_in && !inread) begin
                    m_st[k] = 1;
                end else if (ret && m_cnt[k] == 0) begin
                    m_st[k] = 3; m_cause[k] = 3;
                end else if (ret) begin
                    m_cnt[k]--;
                    m_pc[k] = m_stk[k][m_cnt[k]];
                end else if (call && m_cnt[k] == cfg_depth[k]) begin
                    m_st[k] = 3; m_cause[k] = 2;
                end else if (call) begin
                    m_stk[k][m_cnt[k]] = wrap(k, m_pc[k] + 1);
                    m_cnt[k]++;
                    m_pc[k] = wrap(k, jump_target);
                end else if (jump_en || branch_taken) begin
                    m_pc[k] = wrap(k, jump_target);
                end else begin
                    m_pc[k] = wrap(k, m_pc[k] + 1);
                end
            end else if (m_st[k] == 1) begin
                if (inread) begin m_st[k] = 0; m_pc[k] = wrap(k, m_pc[k] + 1); end
            end else if (m_st[k] == 2) begin
                if (resume) begin m_st[k] = 0; m_pc[k] = wrap(k, m_pc[k] + 1); end
            end
        end
    end

    task automatic cmp_inst(input string tag, input int k, input logic [31:0] p, input logic [1:0] s,
                            input logic [1:0] c, input logic [3:0] n, input logic f, input logic e);
        check({tag, ".pc"}, 64'(p), 64'(m_pc[k]));
        check({tag, ".state"}, 64'(s), 64'(m_st[k]));
        check({tag, ".trap_cause"}, 64'(c), 64'(m_cause[k]));
        check({tag, ".stack_count"}, 64'(n), 64'(m_cnt[k]));
        check({tag, ".stack_full"}, 64'(f), 64'(m_cnt[k] == cfg_depth[k]));
        check({tag, ".stack_empty"}, 64'(e), 64'(m_cnt[k] == 0));
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            cmp_inst("d8", 0, pc_d8, st_d8, tc_d8, cnt_d8, full_d8, empty_d8);
            cmp_inst("d2", 1, pc_d2, st_d2, tc_d2, {2'b00, cnt_d2}, full_d2, empty_d2);
            cmp_inst("a4", 2, {28'd0, pc_a4}, st_a4, tc_a4, cnt_a4, full_a4, empty_a4);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        halt = 0; overflow = 0; wait_in = 0; inread = 0; resume = 0;
        branch_taken = 0; jump_en = 0; call = 0; ret = 0; jump_target = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        cmp_en = 1;

        // Reset state and sequential counting.
        do_reset();
        check("reset_pc", 64'(pc_d8), 64'd0);
        check("reset_state", 64'(st_d8), 64'd0);
        check("reset_empty", 64'(empty_d8), 64'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("idle_pc", 64'(pc_d8), 64'(i));
        end
        check("idle_state", 64'(st_d8), 64'd0);

        // Input wait at pc=3.
        do_reset();
        tick(); tick(); tick();
        check("pre_wait_pc", 64'(pc_d8), 64'd3);
        wait_in = 1; inread = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wait_state", 64'(st_d8), 64'd1);
            check("wait_pc", 64'(pc_d8), 64'd3);
        end
        inread = 1;
        tick();
        check("wait_exit_state", 64'(st_d8), 64'd0);
        check("wait_exit_pc", 64'(pc_d8), 64'd4);
        // wait_in with inread already high retires immediately.
        tick();
        check("wait_inread_pc", 64'(pc_d8), 64'd5);
        clear_inputs();

        // Reset in the middle of WAIT_IN.
        wait_in = 1;
        tick();
        check("wait_again_state", 64'(st_d8), 64'd1);
        reset = 1;
        tick();
        reset = 0; clear_inputs();
        check("midreset_pc", 64'(pc_d8), 64'd0);
        check("midreset_state", 64'(st_d8), 64'd0);

        // Call at pc=2 then ret; then jump and branch.
        do_reset();
        tick(); tick();
        call = 1; jump_target = 32'h40;
        tick();
        check("call_pc", 64'(pc_d8), 64'h40);
        check("call_count", 64'(cnt_d8), 64'd1);
        call = 0; ret = 1;
        tick();
        check("ret_pc", 64'(pc_d8), 64'd3);
        check("ret_count", 64'(cnt_d8), 64'd0);
        ret = 0; jump_en = 1; jump_target = 32'h7;
        tick();
        check("jump_pc", 64'(pc_d8), 64'h7);
        jump_en = 0; branch_taken = 1; jump_target = 32'h9;
        tick();
        check("branch_pc", 64'(pc_d8), 64'h9);
        clear_inputs();

        // Three nested calls: depth-2 instance overflows the stack.
        do_reset();
        call = 1; jump_target = 32'h10; tick();
        jump_target = 32'h20; tick();
        check("d2_full", 64'(full_d2), 64'd1);
        jump_target = 32'h30; tick();
        check("d2_ovf_state", 64'(st_d2), 64'd3);
        check("d2_ovf_cause", 64'(tc_d2), 64'd2);
        check("d2_ovf_pc", 64'(pc_d2), 64'h20);
        check("d8_third_call_pc", 64'(pc_d8), 64'h30);
        call = 0; jump_en = 1; tick();
        call = 0; jump_en = 0; ret = 1; tick();
        check("d2_frozen_pc", 64'(pc_d2), 64'h20);
        check("d2_frozen_count", 64'(cnt_d2), 64'd2);
        clear_inputs();

        // ret with empty stack from reset.
        do_reset();
        ret = 1; tick();
        check("unf_state", 64'(st_d8), 64'd3);
        check("unf_cause", 64'(tc_d8), 64'd3);
        check("unf_pc", 64'(pc_d8), 64'd0);
        clear_inputs();

        // Overflow and halt together: overflow wins; resume has no effect.
        do_reset();
        tick(); tick();
        overflow = 1; halt = 1; tick();
        check("ovf_state", 64'(st_d8), 64'd3);
        check("ovf_cause", 64'(tc_d8), 64'd1);
        check("ovf_pc", 64'(pc_d8), 64'd2);
        overflow = 0; halt = 0; resume = 1; tick();
        check("ovf_resume_state", 64'(st_d8), 64'd3);
        check("ovf_resume_pc", 64'(pc_d8), 64'd2);
        clear_inputs();
        do_reset();
        check("ovf_reset_pc", 64'(pc_d8), 64'd0);
        check("ovf_reset_state", 64'(st_d8), 64'd0);
        check("ovf_reset_cause", 64'(tc_d8), 64'd0);

        // 4-bit PC wraps; halt then resume advances by one.
        for (int i = 0; i < 15; i++) tick();
        check("a4_pc_f", 64'(pc_a4), 64'hF);
        tick();
        check("a4_wrap", 64'(pc_a4), 64'h0);
        check("d8_no_wrap", 64'(pc_d8), 64'd16);
        halt = 1; tick();
        halt = 0;
        check("halt_state", 64'(st_a4), 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold_pc", 64'(pc_a4), 64'h0);
        end
        resume = 1; tick();
        clear_inputs();
        check("resume_state", 64'(st_a4), 64'd0);
        check("resume_pc", 64'(pc_a4), 64'h1);
        check("resume_pc_d8", 64'(pc_d8), 64'd17);
        tick();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
